// File: rtl/serial_logic_unit.sv
// Bit-serial logic unit: evaluates OR/AND/XOR/NOT-x on a WIDTH-bit operand pair
// one bit per clock, LSB first, behind valid/ready handshakes on both sides.
module serial_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel1,
  input  logic             sel0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_OR = 2'b00, OP_AND = 2'b01, OP_XOR = 2'b10, OP_NOT = 2'b11} op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] x_sh, y_sh, r_sh, r_nxt;
  logic [CNT_W-1:0] cnt;
  logic             bit_res;
  logic             last_bit;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    bit_res = 1'b0;
    unique case (op_q)
      OP_OR:  bit_res = x_sh[0] | y_sh[0];
      OP_AND: bit_res = x_sh[0] & y_sh[0];
      OP_XOR: bit_res = x_sh[0] ^ y_sh[0];
      OP_NOT: bit_res = ~x_sh[0];
      default: bit_res = 1'b0;
    endcase
  end

  assign r_nxt    = {bit_res, r_sh[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh <= '0;
      y_sh <= '0;
      r_sh <= '0;
      cnt  <= '0;
      op_q <= OP_OR;
      f    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Operands and opcode are sampled only here; later input changes are ignored.
          if (in_valid) begin
            x_sh <= x;
            y_sh <= y;
            r_sh <= '0;
            op_q <= op_t'({sel1, sel0});
            cnt  <= '0;
          end
        end
        SHIFT: begin
          x_sh <= x_sh >> 1;
          y_sh <= y_sh >> 1;
          r_sh <= r_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last_bit) f <= r_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: handshake timing, opcodes, backpressure,
// operand isolation and asynchronous reset mid-operation.
module tb_serial_logic_unit;

  localparam int WIDTH = 8;
  localparam int LIMIT = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x, y;
  logic             sel1, sel0;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  serial_logic_unit #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sel1(sel1), .sel0(sel0), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Present a command at a negedge and hold in_valid over one accepting edge.
  task automatic send(input logic [7:0] xv, input logic [7:0] yv, input logic [1:0] op);
    int n = 0;
    while (!in_ready && n < LIMIT) begin @(negedge clk); n++; end
    x = xv; y = yv; {sel1, sel0} = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < LIMIT) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; sel1 = 1'b0; sel0 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || f !== 8'h00) begin
      bad++;
      $display("FAIL reset: in_ready/out_valid/busy=%b f=%h, want 100 f=00", {in_ready, out_valid, busy}, f);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_hold;
    bit err = 0;
    repeat (20) begin
      @(negedge clk);
      if ({in_ready, out_valid, busy} !== 3'b100 || f !== 8'h00) err = 1;
    end
    total++;
    if (err) begin
      bad++;
      $display("FAIL idle_hold: in_ready/out_valid/busy=%b f=%h, want 100 f=00", {in_ready, out_valid, busy}, f);
    end
  endtask

  task automatic test_basic;
    int  n = 0;
    bit  ready_err = 0;
    out_ready = 1'b0;
    send(8'h11, 8'h22, 2'b00);
    while (!out_valid && n < LIMIT) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) ready_err = 1;
      @(negedge clk); n++;
    end
    total++;
    if (n !== WIDTH) begin
      bad++; $display("FAIL basic_latency: got %0d cycles, want %0d", n, WIDTH);
    end
    total++;
    if (ready_err) begin
      bad++; $display("FAIL basic_in_ready: in_ready high or busy low during SHIFT, want 0/1");
    end
    total++;
    if (f !== 8'h33 || in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_result: f=%h in_ready=%b busy=%b, want f=33 0 1", f, in_ready, busy);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || f !== 8'h33) begin
      bad++; $display("FAIL basic_retain: out_valid=%b in_ready=%b busy=%b f=%h, want 0 1 0 33", out_valid, in_ready, busy, f);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] xs [3] = '{8'h70, 8'hA1, 8'hC3};
    logic [7:0] ys [3] = '{8'h8F, 8'h0F, 8'hF0};
    logic [1:0] ops[3] = '{2'b01, 2'b10, 2'b11};
    logic [7:0] exp[3] = '{8'h00, 8'hAE, 8'h3C};
    int t[3];
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!in_ready && n < LIMIT) begin @(negedge clk); n++; end
      x = xs[i]; y = ys[i]; {sel1, sel0} = ops[i]; in_valid = 1'b1;
      t[i] = cyc_cnt;
      @(negedge clk);
      if (i == 2) in_valid = 1'b0;
      wait_valid(n);
      total++;
      if (out_valid !== 1'b1 || f !== exp[i]) begin
        bad++; $display("FAIL b2b_result%0d: out_valid=%b f=%h, want 1 f=%h", i, out_valid, f, exp[i]);
      end
      @(negedge clk);
    end
    for (int i = 1; i < 3; i++) begin
      total++;
      if (t[i] - t[i-1] !== WIDTH + 2) begin
        bad++; $display("FAIL b2b_spacing%0d: got %0d cycles, want %0d", i, t[i] - t[i-1], WIDTH + 2);
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    bit err = 0;
    out_ready = 1'b0;
    send(8'hFF, 8'h00, 2'b00);
    wait_valid(n);
    total++;
    if (out_valid !== 1'b1 || f !== 8'hFF) begin
      bad++; $display("FAIL bp_result: out_valid=%b f=%h, want 1 FF", out_valid, f);
    end
    x = 8'h00; y = 8'h00; {sel1, sel0} = 2'b01;
    repeat (5) begin
      in_valid = ~in_valid;
      @(negedge clk);
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || f !== 8'hFF) err = 1;
    end
    total++;
    if (err) begin
      bad++; $display("FAIL bp_stall: out_valid=%b busy=%b in_ready=%b f=%h, want 1 1 0 FF", out_valid, busy, in_ready, f);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || f !== 8'hFF) begin
      bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b f=%h, want 0 1 FF", out_valid, in_ready, f);
    end
  endtask

  task automatic test_isolation;
    int n;
    out_ready = 1'b1;
    x = 8'h0F; y = 8'hF0; {sel1, sel0} = 2'b10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; x = 8'h00; y = 8'h00; {sel1, sel0} = 2'b01;
    wait_valid(n);
    total++;
    if (out_valid !== 1'b1 || f !== 8'hFF) begin
      bad++; $display("FAIL iso_result: out_valid=%b f=%h, want 1 FF", out_valid, f);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL iso_one_cycle: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    out_ready = 1'b1;
    send(8'h3C, 8'h00, 2'b00);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_busy: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || f !== 8'h00) begin
      bad++; $display("FAIL rmid_async: in_ready/out_valid/busy=%b f=%h, want 100 00", {in_ready, out_valid, busy}, f);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h55, 8'hAA, 2'b00);
    wait_valid(n);
    total++;
    if (out_valid !== 1'b1 || f !== 8'hFF) begin
      bad++; $display("FAIL rmid_after: out_valid=%b f=%h, want 1 FF", out_valid, f);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
